// File: rtl/georgios_pkg.sv
// Shared opcode, flag and state definitions for the fetch/decode core.
package georgios_pkg;

    localparam int unsigned OP_W    = 8;
    localparam int unsigned FLAGS_W = 6;

    // Flag index 0 is the leftmost bit of every literal below.
    typedef logic [0:FLAGS_W-1] flags_t;

    localparam logic [OP_W-1:0] OP_NOP  = 8'h00;
    localparam logic [OP_W-1:0] OP_LDI  = 8'h01;
    localparam logic [OP_W-1:0] OP_MOV  = 8'h02;
    localparam logic [OP_W-1:0] OP_ADD  = 8'h03;
    localparam logic [OP_W-1:0] OP_ADDI = 8'h04;
    localparam logic [OP_W-1:0] OP_HLT  = 8'hFF;

    localparam flags_t FLAGS_NONE = 6'b000000;
    localparam flags_t FLAGS_LDI  = 6'b010100;
    localparam flags_t FLAGS_MOV  = 6'b100110;
    localparam flags_t FLAGS_ADD  = 6'b111111;
    localparam flags_t FLAGS_ADDI = 6'b110110;

    typedef enum logic [2:0] {
        FETCH_OP,
        FETCH_A1,
        FETCH_A2,
        FETCH_A3,
        EXEC,
        HALT
    } state_e;

    typedef struct packed {
        flags_t     flags;
        logic [1:0] n_args;
        logic       legal;
        logic       is_halt;
    } decode_t;

endpackage

// File: rtl/fetch_decode_if.sv
// Memory fetch port, downstream stall and router outputs of fetch_decode.
interface fetch_decode_if #(
    parameter int w       = 8,
    parameter int flags_w = 6
);
    logic               mem_req;
    logic [w-1:0]       mem_addr;
    logic               mem_ack;
    logic [w-1:0]       mem_data;
    logic               stall;
    logic [0:flags_w-1] flags;
    logic [w-1:0]       i1;
    logic [w-1:0]       i2;
    logic [w-1:0]       i3;
    logic               valid;
    logic               halted;

    modport master (
        output mem_req, mem_addr, flags, i1, i2, i3, valid, halted,
        input  mem_ack, mem_data, stall
    );

    modport slave (
        input  mem_req, mem_addr, flags, i1, i2, i3, valid, halted,
        output mem_ack, mem_data, stall
    );

endinterface

// File: rtl/op_decode.sv
// Combinational opcode table: router flags, argument count, legality.
module op_decode
    import georgios_pkg::*;
#(
    parameter int w = 8
) (
    input  logic [w-1:0] opcode,
    output decode_t      dec
);

    always_comb begin
        // NOTE: every output gets a default before the case so no path can infer a latch.
        dec = '{flags: FLAGS_NONE, n_args: 2'd0, legal: 1'b0, is_halt: 1'b0};
        case (opcode)
            w'(OP_NOP):  dec.legal = 1'b1;
            w'(OP_LDI):  dec = '{flags: FLAGS_LDI,  n_args: 2'd3, legal: 1'b1, is_halt: 1'b0};
            w'(OP_MOV):  dec = '{flags: FLAGS_MOV,  n_args: 2'd3, legal: 1'b1, is_halt: 1'b0};
            w'(OP_ADD):  dec = '{flags: FLAGS_ADD,  n_args: 2'd3, legal: 1'b1, is_halt: 1'b0};
            w'(OP_ADDI): dec = '{flags: FLAGS_ADDI, n_args: 2'd3, legal: 1'b1, is_halt: 1'b0};
            w'(OP_HLT):  dec = '{flags: FLAGS_NONE, n_args: 2'd0, legal: 1'b1, is_halt: 1'b1};
            default:     dec.legal = 1'b0;
        endcase
    end

endmodule

// File: rtl/fetch_decode.sv
// Byte-serial instruction fetch/decode core feeding router control flags.
// Optional FETCH_ILLEGAL_TRAP_EN: unknown opcodes halt instead of acting as NOP.
module fetch_decode
    import georgios_pkg::*;
#(
    parameter int w       = 8,
    parameter int flags_w = 6
) (
    input  logic          clk,
    input  logic          rst,
    fetch_decode_if.master bus
);

    state_e             state_q, state_d;
    logic [w-1:0]       pc_q, pc_d;
    logic [w-1:0]       op_q, op_d;
    logic [w-1:0]       i1_q, i1_d;
    logic [w-1:0]       i2_q, i2_d;
    logic [w-1:0]       i3_q, i3_d;
    logic [0:flags_w-1] flags_q, flags_d;
    logic               mem_req_q, mem_req_d;
    logic               valid_q, valid_d;
    logic               halted_q, halted_d;

    logic               take;
    logic [w-1:0]       op_sel;
    decode_t            dec;

    // An ack only counts while a request is actually on the bus.
    assign take   = mem_req_q && bus.mem_ack;
    assign op_sel = (state_q == FETCH_OP) ? bus.mem_data : op_q;

    op_decode #(.w(w)) u_op_decode (
        .opcode (op_sel),
        .dec    (dec)
    );

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        op_d    = op_q;
        i1_d    = i1_q;
        i2_d    = i2_q;
        i3_d    = i3_q;

        if (take) begin
            pc_d = pc_q + w'(1);
        end

        case (state_q)
            FETCH_OP: begin
                if (take) begin
                    op_d = bus.mem_data;
                    if (dec.n_args != 2'd0) begin
                        state_d = FETCH_A1;
                    end else if (dec.is_halt) begin
                        state_d = HALT;
`ifdef FETCH_ILLEGAL_TRAP_EN
                    end else if (!dec.legal) begin
                        state_d = HALT;
`else
                    end else if (!dec.legal) begin
                        state_d = EXEC;
`endif
                    end else begin
                        state_d = EXEC;
                    end
                end
            end
            FETCH_A1: if (take) begin i1_d = bus.mem_data; state_d = FETCH_A2; end
            FETCH_A2: if (take) begin i2_d = bus.mem_data; state_d = FETCH_A3; end
            FETCH_A3: if (take) begin i3_d = bus.mem_data; state_d = EXEC;     end
            EXEC:     if (!bus.stall) state_d = FETCH_OP;
            HALT:     state_d = HALT;
            default:  state_d = FETCH_OP;
        endcase

        // Outputs are registered from the next state so they align with it.
        mem_req_d = (state_d == FETCH_OP) || (state_d == FETCH_A1) ||
                    (state_d == FETCH_A2) || (state_d == FETCH_A3);
        valid_d   = (state_d == EXEC);
        flags_d   = valid_d ? dec.flags : '0;
        halted_d  = (state_d == HALT);
    end

    always_ff @(posedge clk) begin
        // NOTE: state updates use non-blocking assignments so all flops see pre-edge values.
        if (rst) begin
            state_q   <= FETCH_OP;
            pc_q      <= '0;
            op_q      <= '0;
            i1_q      <= '0;
            i2_q      <= '0;
            i3_q      <= '0;
            flags_q   <= '0;
            mem_req_q <= 1'b0;
            valid_q   <= 1'b0;
            halted_q  <= 1'b0;
        end else begin
            state_q   <= state_d;
            pc_q      <= pc_d;
            op_q      <= op_d;
            i1_q      <= i1_d;
            i2_q      <= i2_d;
            i3_q      <= i3_d;
            flags_q   <= flags_d;
            mem_req_q <= mem_req_d;
            valid_q   <= valid_d;
            halted_q  <= halted_d;
        end
    end

    assign bus.mem_req  = mem_req_q;
    assign bus.mem_addr = pc_q;
    assign bus.flags    = flags_q;
    assign bus.i1       = i1_q;
    assign bus.i2       = i2_q;
    assign bus.i3       = i3_q;
    assign bus.valid    = valid_q;
    assign bus.halted   = halted_q;

endmodule

// File: tb/tb_fetch_decode.sv
// Scoreboard bench for fetch_decode: stimulus pushes expected fetch addresses
// and EXEC outputs; a monitor pops and compares them as the DUT presents them.
module tb_fetch_decode;
    import georgios_pkg::*;

    localparam int W = 8;

    typedef struct {
        logic [0:5] flags;
        logic [7:0] i1;
        logic [7:0] i2;
        logic [7:0] i3;
        bit         chk_args;
        int         acks;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    fetch_decode_if #(.w(W), .flags_w(6)) bus ();

    fetch_decode #(.w(W), .flags_w(6)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int         checks = 0;
    int         errors = 0;
    logic [7:0] mem [256];
    int         ack_delay = 0;
    logic [7:0] addr_q [$];
    exp_t       exp_q [$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic push_exp(input logic [0:5] f, input logic [7:0] a, input logic [7:0] b,
                            input logic [7:0] c, input bit chk, input int acks);
        exp_q.push_back('{f, a, b, c, chk, acks});
    endtask

    task automatic push_nop();
        push_exp(FLAGS_NONE, 8'h00, 8'h00, 8'h00, 1'b0, 1);
    endtask

    // Memory model: acks after ack_delay idle request cycles.
    initial begin
        int wait_cnt = 0;
        bus.mem_ack  = 1'b0;
        bus.mem_data = '0;
        forever begin
            @(negedge clk);
            if (bus.mem_req) begin
                if (wait_cnt < ack_delay) begin
                    wait_cnt++;
                    bus.mem_ack = 1'b0;
                end else begin
                    wait_cnt     = 0;
                    bus.mem_ack  = 1'b1;
                    bus.mem_data = mem[bus.mem_addr];
                end
            end else begin
                wait_cnt    = 0;
                bus.mem_ack = 1'b0;
            end
        end
    end

    // Monitor: address order/hold on every request cycle, EXEC outputs on every valid cycle.
    initial begin
        int acks_seen = 0;
        exp_t e;
        forever begin
            @(negedge clk);
            #2;
            if (rst) begin
                acks_seen = 0;
            end else begin
                if (bus.mem_req) begin
                    check("fetch_expected", 32'(addr_q.size() != 0), 32'd1);
                    if (addr_q.size() != 0) begin
                        check("mem_addr", 32'(bus.mem_addr), 32'(addr_q[0]));
                        if (bus.mem_ack) begin
                            void'(addr_q.pop_front());
                            acks_seen++;
                        end
                    end
                end
                if (bus.valid) begin
                    check("exec_expected", 32'(exp_q.size() != 0), 32'd1);
                    if (exp_q.size() != 0) begin
                        e = exp_q.pop_front();
                        check("exec_flags", 32'(bus.flags), 32'(e.flags));
                        check("exec_acks", 32'(acks_seen), 32'(e.acks));
                        if (e.chk_args) begin
                            check("exec_i1", 32'(bus.i1), 32'(e.i1));
                            check("exec_i2", 32'(bus.i2), 32'(e.i2));
                            check("exec_i3", 32'(bus.i3), 32'(e.i3));
                        end
                    end
                    acks_seen = 0;
                end else begin
                    check("flags_idle", 32'(bus.flags), 32'd0);
                end
            end
        end
    end

    initial begin
        #300000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic start_test();
        @(negedge clk);
        rst       = 1'b1;
        bus.stall = 1'b0;
        ack_delay = 0;
        @(negedge clk);
        for (int i = 0; i < 256; i++) mem[i] = 8'h00;
    endtask

    task automatic release_rst();
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic wait_halted(input string name, input int bound);
        for (int i = 0; i < bound; i++) begin
            @(negedge clk);
            #2;
            if (bus.halted) break;
        end
        check({name, "_halted"}, 32'(bus.halted), 32'd1);
        check({name, "_halt_req"}, 32'(bus.mem_req), 32'd0);
        check({name, "_halt_valid"}, 32'(bus.valid), 32'd0);
        repeat (3) @(negedge clk);
        #2;
        check({name, "_halt_hold"}, 32'(bus.halted), 32'd1);
        check({name, "_halt_hold_req"}, 32'(bus.mem_req), 32'd0);
        check({name, "_addr_drained"}, 32'(addr_q.size()), 32'd0);
        check({name, "_exec_drained"}, 32'(exp_q.size()), 32'd0);
    endtask

    initial begin
        bus.stall = 1'b0;
        for (int i = 0; i < 256; i++) mem[i] = 8'h00;

        // Reset state.
        start_test();
        #2;
        check("rst_mem_req", 32'(bus.mem_req), 32'd0);
        check("rst_mem_addr", 32'(bus.mem_addr), 32'd0);
        check("rst_valid", 32'(bus.valid), 32'd0);
        check("rst_flags", 32'(bus.flags), 32'd0);
        check("rst_halted", 32'(bus.halted), 32'd0);
        check("rst_i1", 32'(bus.i1), 32'd0);

        // LDI 03 2A 00, ack every cycle, then HLT.
        start_test();
        mem[0] = 8'h01; mem[1] = 8'h03; mem[2] = 8'h2A; mem[3] = 8'h00; mem[4] = 8'hFF;
        for (int a = 0; a < 5; a++) addr_q.push_back(8'(a));
        push_exp(6'b010100, 8'h03, 8'h2A, 8'h00, 1'b1, 4);
        release_rst();
        wait_halted("ldi", 100);

        // ADD with 3 wait cycles per byte.
        start_test();
        ack_delay = 3;
        mem[0] = 8'h03; mem[1] = 8'h11; mem[2] = 8'h22; mem[3] = 8'h33; mem[4] = 8'hFF;
        for (int a = 0; a < 5; a++) addr_q.push_back(8'(a));
        push_exp(6'b111111, 8'h11, 8'h22, 8'h33, 1'b1, 4);
        release_rst();
        wait_halted("add_slow", 200);

        // MOV held in EXEC by stall for 5 cycles.
        start_test();
        bus.stall = 1'b1;
        mem[0] = 8'h02; mem[1] = 8'h05; mem[2] = 8'h06; mem[3] = 8'h07; mem[4] = 8'hFF;
        for (int a = 0; a < 5; a++) addr_q.push_back(8'(a));
        push_exp(6'b100110, 8'h05, 8'h06, 8'h07, 1'b1, 4);
        for (int k = 0; k < 5; k++) push_exp(6'b100110, 8'h05, 8'h06, 8'h07, 1'b1, 0);
        release_rst();
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            #2;
            if (bus.valid) break;
        end
        check("stall_exec_reached", 32'(bus.valid), 32'd1);
        repeat (5) @(negedge clk);
        bus.stall = 1'b0;
        wait_halted("stall", 100);

        // Walk pc to 0xFE, then ADDI fetched across the wrap: FE, FF, 00, 01.
        start_test();
        mem[8'h01] = 8'h01; mem[8'h02] = 8'hFF; mem[8'h03] = 8'h10; mem[8'h04] = 8'h20;
        mem[8'hFE] = 8'h04; mem[8'hFF] = 8'h5A;
        for (int a = 0; a < 256; a++) addr_q.push_back(8'(a));
        addr_q.push_back(8'h00); addr_q.push_back(8'h01); addr_q.push_back(8'h02);
        push_nop();
        push_exp(6'b010100, 8'hFF, 8'h10, 8'h20, 1'b1, 4);
        for (int k = 0; k < 249; k++) push_nop();
        push_exp(6'b110110, 8'h5A, 8'h00, 8'h01, 1'b1, 4);
        release_rst();
        wait_halted("wrap", 2000);

        // Unknown opcode 0x7E.
        start_test();
        mem[0] = 8'h7E; mem[1] = 8'hFF;
`ifdef FETCH_ILLEGAL_TRAP_EN
        addr_q.push_back(8'h00);
`else
        addr_q.push_back(8'h00); addr_q.push_back(8'h01);
        push_nop();
`endif
        release_rst();
        wait_halted("illegal", 100);

        // Reset in FETCH_A2 with an ack in the reset cycle; then HLT at address 0.
        start_test();
        mem[0] = 8'h01; mem[1] = 8'hAA; mem[2] = 8'hBB; mem[3] = 8'hCC; mem[4] = 8'hFF;
        addr_q.push_back(8'h00); addr_q.push_back(8'h01);
        release_rst();
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            #2;
            if (bus.mem_req && bus.mem_ack && bus.mem_addr == 8'h01) break;
        end
        @(negedge clk);
        rst    = 1'b1;
        mem[0] = 8'hFF;
        #2;
        check("mid_a2_addr", 32'(bus.mem_addr), 32'd2);
        check("mid_a2_ack", 32'(bus.mem_ack), 32'd1);
        @(negedge clk);
        #2;
        check("mid_rst_addr", 32'(bus.mem_addr), 32'd0);
        check("mid_rst_req", 32'(bus.mem_req), 32'd0);
        check("mid_rst_valid", 32'(bus.valid), 32'd0);
        check("mid_rst_flags", 32'(bus.flags), 32'd0);
        check("mid_rst_halted", 32'(bus.halted), 32'd0);
        check("mid_rst_i1", 32'(bus.i1), 32'd0);
        check("mid_rst_addr_q", 32'(addr_q.size()), 32'd0);
        addr_q.push_back(8'h00);
        release_rst();
        wait_halted("mid_rst", 100);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
